// File: rtl/axis_modport_pkg.sv
// Shared sizing helpers for the axis_modport stream FIFO.
package axis_modport_pkg;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Index width for a slot array; a single slot still needs one address bit.
  function automatic int unsigned ptr_width(input int unsigned slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

endpackage

// File: rtl/axis_modport_mem.sv
// Unreset register array holding stored beats; synchronous write, asynchronous read.
module axis_modport_mem #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned SLOTS  = 3,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [SLOTS];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/axis_modport.sv
// AXI4-Stream FIFO: DEPTH-1 storage slots feeding one output register, all
// handshake outputs registered so m_tready never reaches s_tready combinationally.
module axis_modport
  import axis_modport_pkg::*;
#(
  parameter int unsigned BYTES  = 1,
  parameter int unsigned USER_W = 1,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [BYTES*8-1:0]         s_tdata,
  input  logic [USER_W-1:0]          s_tuser,
  input  logic                       s_tlast,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  output logic [BYTES*8-1:0]         m_tdata,
  output logic [USER_W-1:0]          m_tuser,
  output logic                       m_tlast,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned DATA_W = BYTES * 8;
  localparam int unsigned SLOTS  = DEPTH - 1;
  localparam int unsigned CNT_W  = cnt_width(DEPTH);
  localparam int unsigned PTR_W  = ptr_width(SLOTS);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [USER_W-1:0] user;
    logic              last;
  } beat_t;

  localparam int unsigned BEAT_W = $bits(beat_t);

  beat_t            out_q, out_d, s_beat, rd_beat;
  logic             m_valid_q, m_valid_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, mem_cnt;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             push, pop, load, bypass, mem_we;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SLOTS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  axis_modport_mem #(
    .WIDTH  (BEAT_W),
    .SLOTS  (SLOTS),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (wr_ptr_q),
    .wr_data (s_beat),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_beat)
  );

  // The output register refills from storage first; an empty store lets a new beat bypass straight in.
  always_comb begin
    s_beat    = '{data: s_tdata, user: s_tuser, last: s_tlast};
    push      = s_tvalid && rdy_q;
    pop       = m_valid_q && m_tready;
    mem_cnt   = cnt_q - CNT_W'(m_valid_q);
    load      = !m_valid_q || pop;
    bypass    = load && (mem_cnt == '0) && push;
    mem_we    = push && !bypass;
    out_d     = out_q;
    m_valid_d = m_valid_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    if (mem_we) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (load) begin
      if (mem_cnt != '0) begin
        out_d     = rd_beat;
        m_valid_d = 1'b1;
        rd_ptr_d  = ptr_inc(rd_ptr_q);
      end else if (push) begin
        out_d     = s_beat;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    rdy_d = cnt_d < CNT_W'(DEPTH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= '0;
      m_valid_q <= 1'b0;
      rdy_q     <= 1'b0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      out_q     <= out_d;
      m_valid_q <= m_valid_d;
      rdy_q     <= rdy_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  assign s_tready = rdy_q;
  assign m_tvalid = m_valid_q;
  assign m_tdata  = out_q.data;
  assign m_tuser  = out_q.user;
  assign m_tlast  = out_q.last;
  assign count    = cnt_q;

endmodule

// File: tb/tb_axis_modport.sv
// Directed and randomized bench for axis_modport with an in-order scoreboard.
module tb_axis_modport;

  logic       clk;
  logic       reset_n;
  logic [7:0] s_tdata;
  logic [0:0] s_tuser;
  logic       s_tlast;
  logic       s_tvalid;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic [0:0] m_tuser;
  logic       m_tlast;
  logic       m_tvalid;
  logic       m_tready;
  logic [2:0] count;

  int         n_vec;
  int         n_err;
  bit         wr_done;
  logic [9:0] exp_q[$];

  axis_modport #(.BYTES(1), .USER_W(1), .DEPTH(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_tdata  (s_tdata),
    .s_tuser  (s_tuser),
    .s_tlast  (s_tlast),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tuser  (m_tuser),
    .m_tlast  (m_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on every output transfer, push on every input transfer.
  always @(negedge clk) begin
    logic [9:0] want;
    if (reset_n) begin
      check("count_max", 32'(count <= 3'd4), 32'd1);
      if (m_tvalid && m_tready) begin
        want = (exp_q.size() == 0) ? 10'h3FF : exp_q.pop_front();
        check("sb_beat", 32'({m_tdata, m_tuser, m_tlast}), 32'(want));
      end
      if (s_tvalid && s_tready) exp_q.push_back({s_tdata, s_tuser, s_tlast});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  acc;
    bit  will;
    bit  stop;
    n_vec    = 0;
    n_err    = 0;
    wr_done  = 1'b0;
    reset_n  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tuser  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_count",    32'(count),    32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_m_tdata",  32'(m_tdata),  32'd0);
    check("rst_m_tuser",  32'(m_tuser),  32'd0);
    check("rst_m_tlast",  32'(m_tlast),  32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("rdy_after_rst", 32'(s_tready), 32'd1);

    // Single beat, one-cycle latency
    m_tready = 1'b1;
    s_tvalid = 1'b1; s_tdata = 8'hA5; s_tuser = 1'b1; s_tlast = 1'b1;
    tick();
    s_tvalid = 1'b0;
    check("single_valid", 32'(m_tvalid), 32'd1);
    check("single_data",  32'(m_tdata),  32'hA5);
    check("single_user",  32'(m_tuser),  32'd1);
    check("single_last",  32'(m_tlast),  32'd1);
    check("single_count", 32'(count),    32'd1);
    tick();
    check("single_empty", 32'(m_tvalid), 32'd0);
    check("single_cnt0",  32'(count),    32'd0);
    check("single_hold",  32'(m_tdata),  32'hA5);

    // Streaming at full throughput
    for (int i = 0; i < 16; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'(i);
      s_tuser  = 1'(i);
      s_tlast  = (i == 15);
      tick();
      check("stream_data",  32'(m_tdata),  32'(i));
      check("stream_count", 32'(count),    32'd1);
      check("stream_rdy",   32'(s_tready), 32'd1);
    end
    s_tvalid = 1'b0;
    tick();
    check("stream_drain", 32'(exp_q.size()), 32'd0);
    check("stream_idle",  32'(m_tvalid),     32'd0);

    // Fill with the sink stalled
    m_tready = 1'b0;
    acc  = 0;
    stop = 1'b0;
    for (int g = 0; g < 10 && !stop; g++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'(8'h20 + acc);
      s_tuser  = 1'b0;
      s_tlast  = 1'b0;
      @(negedge clk);
      will = s_tready;
      tick();
      if (will) acc++;
      else stop = 1'b1;
    end
    s_tvalid = 1'b0;
    check("fill_accepted", 32'(acc),      32'd4);
    check("fill_count",    32'(count),    32'd4);
    check("fill_rdy",      32'(s_tready), 32'd0);
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    check("fill_rdy_back", 32'(s_tready), 32'd1);
    check("fill_count3",   32'(count),    32'd3);
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      m_tready = 1'b1;
      tick();
      m_tready = 1'b0;
      repeat (2) tick();
    end
    check("fill_empty", 32'(count), 32'd0);

    // Stall stability
    s_tvalid = 1'b1; s_tdata = 8'h77; s_tuser = 1'b0; s_tlast = 1'b1;
    tick();
    s_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(m_tvalid), 32'd1);
      check("stall_data",  32'(m_tdata),  32'h77);
      check("stall_user",  32'(m_tuser),  32'd0);
      check("stall_last",  32'(m_tlast),  32'd1);
      tick();
    end
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    check("stall_drain", 32'(exp_q.size()), 32'd0);

    // Random pauses on both sides
    fork
      begin
        for (int b = 0; b < 200; b++) begin
          int  p;
          int  w;
          bit  ok;
          p = int'($urandom_range(0, 3));
          repeat (p) tick();
          s_tvalid = 1'b1;
          s_tdata  = 8'($urandom);
          s_tuser  = 1'($urandom);
          s_tlast  = 1'($urandom);
          w  = 0;
          ok = 1'b0;
          while (!ok && w < 100) begin
            @(negedge clk);
            ok = s_tready;
            tick();
            w++;
          end
          s_tvalid = 1'b0;
          if (!ok) check("wr_timeout", 32'(ok), 32'd1);
        end
        wr_done = 1'b1;
      end
      begin
        int budget;
        budget = 0;
        while (!(wr_done && exp_q.size() == 0 && !m_tvalid) && budget < 20000) begin
          int p;
          p = int'($urandom_range(0, 3));
          m_tready = 1'b0;
          repeat (p) tick();
          m_tready = 1'b1;
          tick();
          budget += p + 1;
        end
        m_tready = 1'b0;
      end
    join
    check("rand_drain", 32'(exp_q.size()), 32'd0);
    check("rand_count", 32'(count),        32'd0);

    // Reset with beats buffered
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'(8'h50 + i);
      s_tuser  = 1'b1;
      s_tlast  = 1'b0;
      tick();
    end
    s_tvalid = 1'b0;
    check("mid_count3", 32'(count),    32'd3);
    check("mid_valid",  32'(m_tvalid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(m_tvalid), 32'd0);
    check("mid_rst_count", 32'(count),    32'd0);
    check("mid_rst_rdy",   32'(s_tready), 32'd0);
    check("mid_rst_data",  32'(m_tdata),  32'd0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("mid_rdy", 32'(s_tready), 32'd1);
    m_tready = 1'b1;
    s_tvalid = 1'b1; s_tdata = 8'h3C; s_tuser = 1'b0; s_tlast = 1'b1;
    tick();
    s_tvalid = 1'b0;
    check("post_valid", 32'(m_tvalid), 32'd1);
    check("post_data",  32'(m_tdata),  32'h3C);
    check("post_count", 32'(count),    32'd1);
    tick();
    check("post_alone", 32'(m_tvalid),     32'd0);
    check("post_cnt0",  32'(count),        32'd0);
    check("post_sb",    32'(exp_q.size()), 32'd0);
    m_tready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
